// File: rtl/gather8x4.sv
// Gathers eight 4-bit words into a parallel frame with valid/ready on both sides.
// Optional early-flush with PAD fill is compiled in when GATHER8X4_FLUSH_EN is defined.
module gather8x4 #(
  parameter logic [3:0] PAD = 4'hF
) (
  input  logic       CLK,
  input  logic       ASYNCRESETN,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] O0,
  output logic [3:0] O1,
  output logic [3:0] O2,
  output logic [3:0] O3,
  output logic [3:0] O4,
  output logic [3:0] O5,
  output logic [3:0] O6,
  output logic [3:0] O7,
  output logic       out_valid,
`ifdef GATHER8X4_FLUSH_EN
  input  logic       flush,
`endif
  input  logic       out_ready
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] slot_q [8];
  logic [3:0] slot_d [8];
  logic       in_xfer, out_xfer;

  assign out_valid = (state_q == HOLD);
  assign in_ready  = (state_q == FILL) | out_ready;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  assign O0 = slot_q[0];
  assign O1 = slot_q[1];
  assign O2 = slot_q[2];
  assign O3 = slot_q[3];
  assign O4 = slot_q[4];
  assign O5 = slot_q[5];
  assign O6 = slot_q[6];
  assign O7 = slot_q[7];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    case (state_q)
      FILL: begin
        if (in_xfer) begin
          slot_d[cnt_q] = in_data;
          cnt_d         = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = HOLD;
        end
`ifdef GATHER8X4_FLUSH_EN
        // Flush sees the post-transfer count; an eighth-word edge already completed.
        if (flush && (state_d == FILL) && (cnt_d != 3'd0)) begin
          for (int unsigned i = 0; i < 8; i++) begin
            if (3'(i) >= cnt_d) slot_d[i] = PAD;
          end
          cnt_d   = 3'd0;
          state_d = HOLD;
        end
`endif
      end
      HOLD: begin
        if (out_xfer) begin
          state_d = FILL;
          cnt_d   = 3'd0;
          if (in_xfer) begin
            slot_d[0] = in_data;
            cnt_d     = 3'd1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= FILL;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < 8; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int unsigned i = 0; i < 8; i++) slot_q[i] <= slot_d[i];
    end
  end

endmodule

// File: doc/gather8x4.md
GATHER8X4 -- requirements
Module: gather8x4

Interface
REQ-001 SHALL have parameter PAD, default 4'hF, the fill value for unreceived slots on flush (AND identity for the downstream 8-input AND stage).
REQ-002 SHALL have port CLK, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port ASYNCRESETN, input, 1 bit, the reset; asynchronous, active-low.
REQ-004 SHALL have port in_data, input, 4 bits, the incoming word.
REQ-005 SHALL have port in_valid, input, 1 bit, signalling that in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit, signalling that the block accepts in_data this cycle.
REQ-007 SHALL have ports O0..O7, output, 4 bits each, the gathered frame; O0 is the first word received.
REQ-008 SHALL have port out_valid, output, 1 bit, signalling that O0..O7 hold a complete frame.
REQ-009 SHALL have port out_ready, input, 1 bit, signalling that the downstream stage consumes the frame.
REQ-010 SHALL have port flush, input, 1 bit, present only when GATHER8X4_FLUSH_EN is defined.

Function
REQ-011 SHALL count an input transfer only on a CLK edge with in_valid=1 and in_ready=1.
REQ-012 SHALL count an output transfer only on a CLK edge with out_valid=1 and out_ready=1.
REQ-013 SHALL implement two states, FILL and HOLD, plus a 3-bit slot index cnt.
REQ-014 SHALL, in FILL, drive in_ready=1 and out_valid=0.
REQ-015 SHALL, on an input transfer in FILL, write in_data into slot cnt and then increment cnt.
REQ-016 SHALL, on an input transfer in FILL with cnt=7, wrap cnt to 0 and enter HOLD, so out_valid=1 on the next cycle (1-cycle latency from the eighth word).
REQ-017 SHALL, in HOLD, drive out_valid=1, drive in_ready=out_ready (combinational), and keep O0..O7 stable until an output transfer.
REQ-018 SHALL, on an output transfer in HOLD with no input transfer, enter FILL with cnt=0.
REQ-019 SHALL, on simultaneous input and output transfers in HOLD, write in_data to slot 0, set cnt=1, and enter FILL (back-to-back frames, no bubble).
REQ-020 SHALL, while a frame is being filled in FILL, hold unwritten slots at their previous contents; O0..O7 are meaningful only while out_valid=1.
REQ-021 SHALL leave in_valid=1 with in_ready=0 as a stall: in_data is not written and state is unchanged.
REQ-022 SHALL leave state unchanged when in_valid=0 in FILL.

Reset
REQ-023 SHALL, while ASYNCRESETN=0, immediately force state=FILL, cnt=0, O0..O7=4'h0 and out_valid=0; in_ready=1 follows from FILL.
REQ-024 SHALL, on reset mid-frame or during HOLD, discard the partial or pending frame with no output transfer.
REQ-025 SHALL, on the first CLK edge after ASYNCRESETN rises, accept an input transfer normally.

Configuration
REQ-026 SHALL compile the flush feature only when the macro GATHER8X4_FLUSH_EN is defined.
REQ-027 SHALL, with GATHER8X4_FLUSH_EN defined, on a flush=1 edge in FILL: first apply any same-edge input transfer, then fill slots from the resulting cnt through 7 with PAD, set cnt=0, and enter HOLD.
REQ-028 SHALL, with GATHER8X4_FLUSH_EN defined, ignore flush in FILL when the resulting cnt is 0 (empty frame) and ignore flush in HOLD.
REQ-029 SHALL, with GATHER8X4_FLUSH_EN defined, treat a flush edge coinciding with the eighth word as a normal completion with no padding.
REQ-030 SHALL, without GATHER8X4_FLUSH_EN, have no flush port and transfer only complete 8-word frames.

Verification
REQ-031 SHALL cover a basic frame: after reset, send words 1..8 with out_ready=0 -> out_valid=1 one cycle after word 8, O0..O7=1..8, in_ready=0.
REQ-032 SHALL cover stall: hold out_ready=0 for 5 cycles with in_valid=1 and in_data=4'hA -> O unchanged, no slot written, then out_ready=1 -> FILL with cnt=0.
REQ-033 SHALL cover back-to-back: in HOLD, drive out_ready=1, in_valid=1, in_data=4'h5 -> frame consumed, next O0=4'h5, cnt=1, no idle cycle.
REQ-034 SHALL cover reset mid-frame: reset asserted after 3 words -> outputs zero immediately; the next 8 words form a clean frame.
REQ-035 SHALL cover flush (GATHER8X4_FLUSH_EN): send 3,7,9 then flush -> O0..O2=3,7,9, O3..O7=4'hF, out_valid=1 next cycle; flush at cnt=0 -> no change.
REQ-036 SHALL cover the downstream check: feed each frame into the 8x4 AND stage -> its 4-bit result equals the bitwise AND of O0..O7, including padded frames.
